// File: rtl/enemy_formation_mover_if.sv
// Bundle of signals between the VGA/game logic (master) and the
// enemy formation mover (slave). Clock and reset are not part of it.
interface enemy_formation_mover_if #(
    parameter int N_ENEMIES = 4
);
    // Inputs to the mover
    logic                 startOfFrame;
    logic [10:0]          pixelX;
    logic [10:0]          pixelY;
    logic                 changeDirection;
    logic                 dodgeBullet;
    logic [N_ENEMIES-1:0] shotCollision;
    logic                 pause;

    // Outputs from the mover
    logic [10:0]          topLeftX;
    logic [10:0]          topLeftY;
    logic                 drawingRequest;
    logic [10:0]          offsetX;
    logic [10:0]          offsetY;
    logic [2:0]           drawIndex;
    logic [N_ENEMIES-1:0] aliveMask;
    logic                 allDead;
    logic                 reachedBottom;
    logic [3:0]           waveCount;

    modport master (
        output startOfFrame, pixelX, pixelY, changeDirection, dodgeBullet,
               shotCollision, pause,
        input  topLeftX, topLeftY, drawingRequest, offsetX, offsetY,
               drawIndex, aliveMask, allDead, reachedBottom, waveCount
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, changeDirection, dodgeBullet,
               shotCollision, pause,
        output topLeftX, topLeftY, drawingRequest, offsetX, offsetY,
               drawIndex, aliveMask, allDead, reachedBottom, waveCount
    );
endinterface

// File: rtl/enemy_formation_mover.sv
// Moves a row of N_ENEMIES sprites as one fixed-point formation: bounces
// between screen edges, optionally steps down on each reversal, tracks
// which enemies are alive and respawns a faster wave once all are dead.
// Also resolves which enemy (if any) covers the current VGA pixel.
// The interface instance must use the same N_ENEMIES as this module.
module enemy_formation_mover #(
    parameter int N_ENEMIES       = 4,
    parameter int INITIAL_X       = 100,
    parameter int INITIAL_Y       = 60,
    parameter int OBJECT_WIDTH_X  = 30,
    parameter int OBJECT_HEIGHT_Y = 30,
    parameter int SPACING_X       = 50,
    parameter int SCREEN_W        = 640,
    parameter int FRAC_BITS       = 6,
    parameter int X_SPEED         = 120,
    parameter int SPEED_INC       = 32,
    parameter int SPEED_MAX       = 320,
    parameter int MODE            = 1,
    parameter int DESCEND_FRAMES  = 8,
    parameter int Y_SPEED         = 128,
    parameter int Y_LIMIT         = 400,
    parameter int DODGE_WAIT      = 35,
    parameter int RESPAWN_FRAMES  = 60
) (
    input  logic                   clk,
    input  logic                   resetN,
    enemy_formation_mover_if.slave bus
);

    // Formation width is fixed regardless of which enemies are alive,
    // so the bounce bounds never jump when an edge enemy is shot.
    localparam int W_F       = (N_ENEMIES - 1) * SPACING_X + OBJECT_WIDTH_X;
    localparam int FP_ONE    = 1 << FRAC_BITS;
    localparam int MAX_X_FP  = (SCREEN_W - W_F) * FP_ONE;
    localparam int INIT_X_FP = INITIAL_X * FP_ONE;
    localparam int INIT_Y_FP = INITIAL_Y * FP_ONE;
    localparam logic [N_ENEMIES-1:0] ALL_ALIVE = '1;

    typedef enum logic [1:0] {
        S_RUN,
        S_DESCEND,
        S_CLEARED
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Fixed-point formation state
    logic signed [31:0]   r_x;
    logic signed [31:0]   r_y;
    logic signed [31:0]   r_speed;
    logic                 r_dir;          // 1 = moving right, 0 = moving left

    // Frame-based timers
    logic [15:0]          r_desc_cnt;
    logic [15:0]          r_resp_cnt;
    logic [15:0]          r_dodge_cnt;

    logic [N_ENEMIES-1:0] r_alive;
    logic                 r_reached_bottom;
    logic [3:0]           r_wave;
    logic                 r_change_d;

    // Registered draw outputs
    logic                 r_draw_req;
    logic [10:0]          r_off_x;
    logic [10:0]          r_off_y;
    logic [2:0]           r_draw_idx;

    // Combinational helpers
    logic                 w_in_run;
    logic                 w_in_descend;
    logic                 w_in_cleared;
    logic                 w_frame;
    logic                 w_active_run;
    logic signed [31:0]   w_step;
    logic signed [31:0]   w_next_x;
    logic                 w_clamp_lo;
    logic                 w_clamp_hi;
    logic                 w_clamp;
    logic                 w_change_edge;
    logic                 w_dodge_fire;
    logic                 w_toggle;
    logic                 w_all_killed;
    logic                 w_respawn;
    logic                 w_enter_descend;
    logic                 w_enter_cleared;
    logic signed [31:0]   w_speed_inc;
    logic signed [31:0]   w_speed_next;
    int                   w_tlx;
    int                   w_tly;
    int                   w_px;
    int                   w_py;
    logic                 w_hit;
    logic [2:0]           w_hit_idx;
    logic [10:0]          w_hit_off_x;
    logic [10:0]          w_hit_off_y;

    // Pause freezes everything frame-driven; kills and drawing keep going.
    assign w_frame       = bus.startOfFrame & ~bus.pause;
    assign w_active_run  = w_in_run & ~bus.pause;

    // Horizontal step and edge clamping for the RUN frame update
    assign w_step        = r_dir ? r_speed : -r_speed;
    assign w_next_x      = r_x + w_step;
    assign w_clamp_lo    = (w_next_x < 0);
    assign w_clamp_hi    = (w_next_x > MAX_X_FP);
    assign w_clamp       = w_frame & w_in_run & (w_clamp_lo | w_clamp_hi);

    // Reversal requests; a clamp owns dir this cycle, and dodge plus
    // change-direction together still flip dir only once.
    assign w_change_edge = bus.changeDirection & ~r_change_d;
    assign w_dodge_fire  = w_active_run & bus.dodgeBullet & (r_dodge_cnt == '0) & ~w_clamp;
    assign w_toggle      = w_active_run & ~w_clamp & (w_dodge_fire | w_change_edge);

    assign w_all_killed    = (r_alive == '0);
    assign w_respawn       = w_in_cleared & (w_next_state == S_RUN);
    assign w_enter_descend = w_in_run & (w_next_state == S_DESCEND);
    assign w_enter_cleared = ~w_in_cleared & (w_next_state == S_CLEARED);

    assign w_speed_inc  = r_speed + SPEED_INC;
    assign w_speed_next = (w_speed_inc > SPEED_MAX) ? SPEED_MAX : w_speed_inc;

    // Integer pixel position of the formation
    assign w_tlx = r_x >>> FRAC_BITS;
    assign w_tly = r_y >>> FRAC_BITS;
    assign w_px  = {21'd0, bus.pixelX};
    assign w_py  = {21'd0, bus.pixelY};

    // FSM state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_RUN;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its inputs.
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; pause holds the current state
    always_comb begin
        // NOTE: default first so no path leaves w_next_state unassigned,
        // which would otherwise infer a latch.
        w_next_state = r_state;
        if (!bus.pause) begin
            case (r_state)
                S_RUN: begin
                    if (w_all_killed)
                        w_next_state = S_CLEARED;
                    else if (w_clamp && (MODE == 1))
                        w_next_state = S_DESCEND;
                end
                S_DESCEND: begin
                    if (w_all_killed)
                        w_next_state = S_CLEARED;
                    else if (r_desc_cnt == '0)
                        w_next_state = S_RUN;
                end
                S_CLEARED: begin
                    if (r_resp_cnt == '0)
                        w_next_state = S_RUN;
                end
                default: w_next_state = S_RUN;
            endcase
        end
    end

    // FSM state decode used by the datapath
    always_comb begin
        w_in_run     = 1'b0;
        w_in_descend = 1'b0;
        w_in_cleared = 1'b0;
        case (r_state)
            S_RUN:     w_in_run     = 1'b1;
            S_DESCEND: w_in_descend = 1'b1;
            S_CLEARED: w_in_cleared = 1'b1;
            default:   w_in_run     = 1'b0;
        endcase
    end

    // Formation position: X moves in RUN, Y steps during DESCEND
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_x <= INIT_X_FP;
            r_y <= INIT_Y_FP;
        end else if (w_respawn) begin
            r_x <= INIT_X_FP;
            r_y <= INIT_Y_FP;
        end else if (w_frame && w_in_run) begin
            if (w_clamp_lo)
                r_x <= 0;
            else if (w_clamp_hi)
                r_x <= MAX_X_FP;
            else
                r_x <= w_next_x;
        end else if (w_frame && w_in_descend && (r_desc_cnt != '0)) begin
            r_y <= r_y + Y_SPEED;
        end
    end

    // Direction: clamp forces it, otherwise a single toggle per request
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_dir <= 1'b1;
        end else if (w_respawn) begin
            r_dir <= 1'b1;
        end else if (w_clamp) begin
            r_dir <= w_clamp_lo;
        end else if (w_toggle) begin
            r_dir <= ~r_dir;
        end
    end

    // Descent, respawn and dodge-lockout frame counters
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_desc_cnt  <= '0;
            r_resp_cnt  <= '0;
            r_dodge_cnt <= '0;
        end else begin
            if (w_enter_descend)
                r_desc_cnt <= 16'(DESCEND_FRAMES);
            else if (w_frame && w_in_descend && (r_desc_cnt != '0))
                r_desc_cnt <= r_desc_cnt - 16'd1;

            if (w_enter_cleared)
                r_resp_cnt <= 16'(RESPAWN_FRAMES);
            else if (w_frame && w_in_cleared && (r_resp_cnt != '0))
                r_resp_cnt <= r_resp_cnt - 16'd1;

            if (w_respawn)
                r_dodge_cnt <= '0;
            else if (w_dodge_fire)
                r_dodge_cnt <= 16'(DODGE_WAIT);
            else if (w_frame && (r_dodge_cnt != '0))
                r_dodge_cnt <= r_dodge_cnt - 16'd1;
        end
    end

    // Alive mask, wave speed-up and wave counter
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_alive <= ALL_ALIVE;
            r_speed <= X_SPEED;
            r_wave  <= '0;
        end else if (w_respawn) begin
            r_alive <= ALL_ALIVE;
            r_speed <= w_speed_next;
            r_wave  <= r_wave + 4'd1;
        end else if (!w_in_cleared) begin
            r_alive <= r_alive & ~bus.shotCollision;
        end
    end

    // Sticky bottom flag and change-direction edge detector
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_reached_bottom <= 1'b0;
            r_change_d       <= 1'b0;
        end else begin
            r_change_d <= bus.changeDirection;
            if (w_respawn)
                r_reached_bottom <= 1'b0;
            else if (w_tly >= Y_LIMIT)
                r_reached_bottom <= 1'b1;
        end
    end

    // Hit test: lowest-index alive enemy whose box covers the pixel wins
    always_comb begin
        w_hit       = 1'b0;
        w_hit_idx   = '0;
        w_hit_off_x = '0;
        w_hit_off_y = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            if (!w_hit && r_alive[i] &&
                (w_px >= w_tlx + i * SPACING_X) &&
                (w_px <  w_tlx + i * SPACING_X + OBJECT_WIDTH_X) &&
                (w_py >= w_tly) &&
                (w_py <  w_tly + OBJECT_HEIGHT_Y)) begin
                w_hit       = 1'b1;
                w_hit_idx   = 3'(i);
                w_hit_off_x = 11'(w_px - w_tlx - i * SPACING_X);
                w_hit_off_y = 11'(w_py - w_tly);
            end
        end
    end

    // Draw outputs registered for one cycle of latency
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_draw_req <= 1'b0;
            r_draw_idx <= '0;
            r_off_x    <= '0;
            r_off_y    <= '0;
        end else begin
            r_draw_req <= w_hit;
            r_draw_idx <= w_hit_idx;
            r_off_x    <= w_hit_off_x;
            r_off_y    <= w_hit_off_y;
        end
    end

    assign bus.topLeftX       = w_tlx[10:0];
    assign bus.topLeftY       = w_tly[10:0];
    assign bus.drawingRequest = r_draw_req;
    assign bus.offsetX        = r_off_x;
    assign bus.offsetY        = r_off_y;
    assign bus.drawIndex      = r_draw_idx;
    assign bus.aliveMask      = r_alive;
    assign bus.allDead        = w_in_cleared;
    assign bus.reachedBottom  = r_reached_bottom;
    assign bus.waveCount      = r_wave;

endmodule

// File: tb/tb_enemy_formation_mover.sv
// Directed bench for enemy_formation_mover. Expected values are
// hand-derived from the formation rules (fixed point x64, speed 120,
// right clamp 29440 = 460 px). Y_LIMIT is lowered to 70 so the bottom
// flag is reachable during a single descent.
module tb_enemy_formation_mover;

    logic clk;
    logic resetN;
    int   n_cmp;
    int   n_err;

    enemy_formation_mover_if #(.N_ENEMIES(4)) bus ();

    enemy_formation_mover #(
        .N_ENEMIES (4),
        .Y_LIMIT   (70)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle frame pulse followed by idle cycles so all effects settle
    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            bus.startOfFrame = 1'b1;
            @(negedge clk);
            bus.startOfFrame = 1'b0;
            tick(3);
        end
    endtask

    task automatic pixel(input int px, input int py);
        bus.pixelX = 11'(px);
        bus.pixelY = 11'(py);
        tick(1);
    endtask

    task automatic do_reset();
        resetN              = 1'b0;
        bus.startOfFrame    = 1'b0;
        bus.pixelX          = '0;
        bus.pixelY          = '0;
        bus.changeDirection = 1'b0;
        bus.dodgeBullet     = 1'b0;
        bus.shotCollision   = '0;
        bus.pause           = 1'b0;
        tick(2);
        resetN = 1'b1;
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;

        // ---- Reset state ----
        do_reset();
        check("rst_tlx",   32'(bus.topLeftX), 100);
        check("rst_tly",   32'(bus.topLeftY), 60);
        check("rst_alive", 32'(bus.aliveMask), 4'b1111);
        check("rst_dead",  32'(bus.allDead), 0);
        check("rst_bot",   32'(bus.reachedBottom), 0);
        check("rst_wave",  32'(bus.waveCount), 0);
        check("rst_req",   32'(bus.drawingRequest), 0);
        check("rst_idx",   32'(bus.drawIndex), 0);

        // ---- Drawing at the reset position ----
        pixel(100, 60);
        check("d0_req",  32'(bus.drawingRequest), 1);
        check("d0_offx", 32'(bus.offsetX), 0);
        check("d0_offy", 32'(bus.offsetY), 0);
        check("d0_idx",  32'(bus.drawIndex), 0);
        pixel(129, 89);
        check("d0c_req",  32'(bus.drawingRequest), 1);
        check("d0c_offx", 32'(bus.offsetX), 29);
        check("d0c_offy", 32'(bus.offsetY), 29);
        pixel(130, 60);
        check("gap_req",  32'(bus.drawingRequest), 0);
        check("gap_offx", 32'(bus.offsetX), 0);
        pixel(100, 90);
        check("below_req", 32'(bus.drawingRequest), 0);
        pixel(250, 60);
        check("d3_req", 32'(bus.drawingRequest), 1);
        check("d3_idx", 32'(bus.drawIndex), 3);

        // ---- Kill enemy 1 ----
        bus.shotCollision = 4'b0010;
        tick(1);
        bus.shotCollision = 4'b0000;
        check("kill1_alive", 32'(bus.aliveMask), 4'b1101);
        pixel(155, 65);
        check("dead1_req",  32'(bus.drawingRequest), 0);
        check("dead1_idx",  32'(bus.drawIndex), 0);
        check("dead1_offx", 32'(bus.offsetX), 0);
        pixel(205, 65);
        check("d2_req",  32'(bus.drawingRequest), 1);
        check("d2_idx",  32'(bus.drawIndex), 2);
        check("d2_offx", 32'(bus.offsetX), 5);
        check("d2_offy", 32'(bus.offsetY), 5);
        pixel(280, 60);
        check("right_req", 32'(bus.drawingRequest), 0);

        // ---- One frame: 6400 -> 6520 ----
        frames(1);
        check("f1_tlx", 32'(bus.topLeftX), 101);

        // ---- Dodge held: reverse now, again after 35 frames ----
        bus.dodgeBullet = 1'b1;
        tick(1);
        frames(1);                              // 6520-120 = 6400
        check("dodge1_tlx", 32'(bus.topLeftX), 100);
        frames(34);                             // 6520-35*120 = 2320
        check("dodge35_tlx", 32'(bus.topLeftX), 36);
        frames(1);                              // reversed again: 2440
        check("dodge36_tlx", 32'(bus.topLeftX), 38);
        frames(4);                              // 2920
        check("dodge40_tlx", 32'(bus.topLeftX), 45);
        bus.dodgeBullet = 1'b0;

        // ---- Dodge + change edge together: single toggle ----
        do_reset();
        bus.dodgeBullet     = 1'b1;
        bus.changeDirection = 1'b1;
        tick(1);
        bus.dodgeBullet = 1'b0;
        frames(1);                              // 6400-120 = 6280
        check("combo_tlx", 32'(bus.topLeftX), 98);
        bus.changeDirection = 1'b0;
        tick(1);
        bus.changeDirection = 1'b1;
        tick(1);
        frames(1);                              // right again: 6400
        check("chg_tlx", 32'(bus.topLeftX), 100);
        frames(2);                              // held high, no retoggle: 6640
        check("chg_hold_tlx", 32'(bus.topLeftX), 103);
        bus.changeDirection = 1'b0;

        // ---- Right edge clamp and descent ----
        do_reset();
        frames(192);                            // exactly 29440, not past
        check("edge_pre_tlx", 32'(bus.topLeftX), 460);
        frames(1);                              // clamp, enter DESCEND
        check("clamp_tlx", 32'(bus.topLeftX), 460);
        check("clamp_tly", 32'(bus.topLeftY), 60);
        frames(4);
        check("desc4_tly", 32'(bus.topLeftY), 68);
        check("desc4_tlx", 32'(bus.topLeftX), 460);
        check("desc4_bot", 32'(bus.reachedBottom), 0);
        frames(1);
        check("desc5_tly", 32'(bus.topLeftY), 70);
        check("desc5_bot", 32'(bus.reachedBottom), 1);
        frames(3);
        check("desc8_tly", 32'(bus.topLeftY), 76);
        check("desc8_tlx", 32'(bus.topLeftX), 460);
        frames(1);                              // RUN, moving left: 29320
        check("run_left_tlx", 32'(bus.topLeftX), 458);
        check("run_left_tly", 32'(bus.topLeftY), 76);

        // ---- Kill all, respawn after 60 frames ----
        bus.shotCollision = 4'b1111;
        tick(1);
        bus.shotCollision = 4'b0000;
        check("killall_alive", 32'(bus.aliveMask), 0);
        check("killall_dead1", 32'(bus.allDead), 0);
        tick(1);
        check("killall_dead2", 32'(bus.allDead), 1);
        frames(59);
        check("resp59_dead", 32'(bus.allDead), 1);
        check("resp59_wave", 32'(bus.waveCount), 0);
        frames(1);
        check("resp_dead",  32'(bus.allDead), 0);
        check("resp_tlx",   32'(bus.topLeftX), 100);
        check("resp_tly",   32'(bus.topLeftY), 60);
        check("resp_alive", 32'(bus.aliveMask), 4'b1111);
        check("resp_wave",  32'(bus.waveCount), 1);
        check("resp_bot",   32'(bus.reachedBottom), 0);
        frames(1);                              // speed 152: 6552
        check("resp_speed_tlx", 32'(bus.topLeftX), 102);

        // ---- Pause during descent ----
        do_reset();
        frames(193);
        frames(2);
        check("pdesc2_tly", 32'(bus.topLeftY), 64);
        bus.pause = 1'b1;
        frames(10);
        check("paused_tly", 32'(bus.topLeftY), 64);
        check("paused_tlx", 32'(bus.topLeftX), 460);
        bus.shotCollision = 4'b0001;
        tick(1);
        bus.shotCollision = 4'b0000;
        check("paused_kill", 32'(bus.aliveMask), 4'b1110);
        bus.pause = 1'b0;
        frames(6);                              // remaining 6 descent frames
        check("unpause_tly", 32'(bus.topLeftY), 76);
        check("unpause_tlx", 32'(bus.topLeftX), 460);
        frames(1);
        check("unpause_run_tlx", 32'(bus.topLeftX), 458);

        // ---- Async reset in the middle of a respawn wait ----
        bus.shotCollision = 4'b1110;
        tick(1);
        bus.shotCollision = 4'b0000;
        tick(1);
        check("mid_dead", 32'(bus.allDead), 1);
        frames(5);
        #2 resetN = 1'b0;
        #1;
        check("async_dead",  32'(bus.allDead), 0);
        check("async_tlx",   32'(bus.topLeftX), 100);
        check("async_alive", 32'(bus.aliveMask), 4'b1111);
        tick(1);
        resetN = 1'b1;
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
